// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: sequential PC generation, one outstanding imem request, DEPTH-entry queue to decode.
// Optional same-cycle ack-to-decode bypass is enabled by defining IFQ_BYPASS_EN.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [1:0]  fsm_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [63:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [63:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic head_valid;
    logic ack_take;
    logic push;
    logic pop;

    // Decode handshake: a head entry transfers when if_valid && id_ready in the same
    // cycle (and no redirect); if_instr/if_pc hold steady while if_valid && !id_ready.
    assign head_valid = (count != '0);
    assign ack_take   = (state == WAIT) && imem_ack && !redirect;
    assign pop        = head_valid && id_ready && !redirect;

`ifdef IFQ_BYPASS_EN
    logic bypass_avail;
    logic bypass_take;
    assign bypass_avail = !head_valid && ack_take;
    assign bypass_take  = bypass_avail && id_ready;
    assign push         = ack_take && !bypass_take;
`else
    assign push         = ack_take;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!redirect && (count < DEPTH_C)) state_nxt = WAIT;
            WAIT: begin
                if (imem_ack)      state_nxt = IDLE;
                else if (redirect) state_nxt = DROP;
            end
            DROP: if (imem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state == WAIT) || (state == DROP);
        fsm_state = state;
    end

    // Pointer, count and PC bookkeeping; a redirect flushes and wins over push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            if ((state == IDLE) && (state_nxt == WAIT)) imem_addr <= fetch_pc;
            if (redirect) begin
                fetch_pc <= redirect_pc & ~64'h3;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (ack_take) fetch_pc <= fetch_pc + 64'd4;
                if (push)     wr_ptr   <= wr_ptr + AW'(1);
                if (pop)      rd_ptr   <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

    always_comb begin
        if_valid = head_valid;
        if_instr = head_valid ? instr_mem[rd_ptr] : 32'h0;
        if_pc    = head_valid ? pc_mem[rd_ptr]    : 64'h0;
`ifdef IFQ_BYPASS_EN
        if (bypass_avail) begin
            if_valid = 1'b1;
            if_instr = imem_rdata;
            if_pc    = fetch_pc;
        end
`endif
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: stimulus table, directed corner sequences and a random run,
// all checked against a transaction-level queue model of the fetch front end.
module tb_instr_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h100;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [1:0]  fsm_state;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 1;
    bit rand_ack = 1'b0;
    int wait_cnt = 0;

    logic [95:0] exp_q[$];   // {pc, instr}
    int          m_pend;     // 0 none, 1 live request, 2 request to be discarded
    logic [63:0] m_fetch;
    logic [63:0] m_req_addr;
    bit          m_valid = 1'b0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_mem();
        if (imem_req) begin
            if (rand_ack) imem_ack = ($urandom_range(0, 2) == 0);
            else          imem_ack = (wait_cnt >= lat - 1);
        end else begin
            imem_ack = rand_ack ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        imem_rdata = (imem_req && imem_ack) ? mem_word(imem_addr) : $urandom();
    endtask

    task automatic check_model();
        if (!m_valid) return;
        chk("imem_req", imem_req, 64'(m_pend != 0));
        if (m_pend != 0) chk("imem_addr", imem_addr, m_req_addr);
        chk("if_valid", if_valid, 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("if_pc", if_pc, exp_q[0][95:32]);
            chk("if_instr", 64'(if_instr), 64'(exp_q[0][31:0]));
        end
    endtask

    task automatic update_model();
        int sz;
        if (reset) begin
            exp_q.delete();
            m_fetch = RPC;
            m_pend  = 0;
            m_valid = 1'b1;
        end else if (!m_valid) begin
            // model not yet synchronised
        end else if (redirect) begin
            exp_q.delete();
            m_fetch = {redirect_pc[63:2], 2'b00};
            if (m_pend != 0 && imem_ack) m_pend = 0;
            else if (m_pend == 1)        m_pend = 2;
        end else begin
            sz = exp_q.size();
            if (sz > 0 && id_ready) void'(exp_q.pop_front());
            if (m_pend != 0) begin
                if (imem_ack) begin
                    if (m_pend == 1) begin
                        exp_q.push_back({m_req_addr, imem_rdata});
                        m_fetch = m_fetch + 64'd4;
                    end
                    m_pend = 0;
                end
            end else if (sz < DEPTH) begin
                m_pend     = 1;
                m_req_addr = m_fetch;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic rdy, input logic rd, input logic [63:0] rpc);
        @(posedge clk);
        #1;
        reset       = r;
        id_ready    = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        drive_mem();
        @(negedge clk);
        check_model();
        update_model();
        if (reset || !imem_req || imem_ack) wait_cnt = 0;
        else                                wait_cnt++;
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rd;
        logic [63:0] rpc;
        logic        chk_en;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [63:0] e_pc;
    } vec_t;

    vec_t vecs[12];

    int          acks;
    bit          seen;
    bit          done;
    logic [63:0] popped[$];
    logic        r_rst, r_rd;
    logic [63:0] r_pc;

    initial begin
        reset = 1'b1; id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;

        // Reset, 1-cycle memory, decode always ready; then a redirect landing with an ack.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 64'h0,    1'b0, 1'b0, 64'h0,    1'b0, 64'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b1, 1'b0, 64'h100,  1'b0, 64'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b1, 1'b1, 64'h100,  1'b0, 64'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b1, 1'b0, 64'h100,  1'b1, 64'h100};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b1, 1'b1, 64'h104,  1'b0, 64'h0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b1, 1'b0, 64'h104,  1'b1, 64'h104};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b1, 1'b1, 64'h108,  1'b0, 64'h0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b1, 1'b0, 64'h108,  1'b1, 64'h108};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 64'h2002, 1'b1, 1'b1, 64'h10C,  1'b0, 64'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b1, 1'b0, 64'h10C,  1'b0, 64'h0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b1, 1'b1, 64'h2000, 1'b0, 64'h0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b1, 1'b0, 64'h2000, 1'b1, 64'h2000};

        lat = 1;
        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].rdy, vecs[i].rd, vecs[i].rpc);
            if (vecs[i].chk_en) begin
                chk("tbl_req", imem_req, vecs[i].e_req);
                chk("tbl_addr", imem_addr, vecs[i].e_addr);
                chk("tbl_valid", if_valid, vecs[i].e_valid);
                if (vecs[i].e_valid) begin
                    chk("tbl_pc", if_pc, vecs[i].e_pc);
                    chk("tbl_instr", 64'(if_instr), 64'(mem_word(vecs[i].e_pc)));
                end
            end
        end

        // Backpressure: queue fills to DEPTH, fetching stops, then drains in order.
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        cycle(1'b0, 1'b0, 1'b0, 64'h0);
        chk("reset_if_valid", if_valid, 0);
        chk("reset_if_pc", if_pc, 64'h0);
        chk("reset_if_instr", 64'(if_instr), 64'h0);
        acks = 0;
        repeat (19) begin
            cycle(1'b0, 1'b0, 1'b0, 64'h0);
            if (imem_req && imem_ack) acks++;
        end
        chk("fill_req_count", 64'(acks), 64'd4);
        chk("fill_req_idle", imem_req, 0);
        chk("fill_head_pc", if_pc, 64'h100);
        popped.delete();
        seen = 1'b0;
        for (int c = 0; c < 40 && popped.size() < 5; c++) begin
            cycle(1'b0, 1'b1, 1'b0, 64'h0);
            if (if_valid) popped.push_back(if_pc);
            if (imem_req && !seen) begin
                seen = 1'b1;
                chk("resume_addr", imem_addr, 64'h110);
            end
        end
        chk("drain_count", 64'(popped.size()), 64'd5);
        for (int i = 0; i < popped.size(); i++) chk("drain_order", popped[i], 64'h100 + 64'(4 * i));

        // Redirect while a 3-cycle request to 0x108 is outstanding: late data is discarded.
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        lat  = 3;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            cycle(1'b0, 1'b0, 1'b0, 64'h0);
            if (imem_req && imem_addr == 64'h108 && wait_cnt == 1) done = 1'b1;
        end
        chk("late_found", done, 1);
        cycle(1'b0, 1'b0, 1'b1, 64'h2002);
        cycle(1'b0, 1'b0, 1'b0, 64'h0);
        chk("drop_req", imem_req, 1);
        chk("drop_addr", imem_addr, 64'h108);
        chk("drop_ack", imem_ack, 1);
        chk("drop_valid", if_valid, 0);
        seen = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            cycle(1'b0, 1'b0, 1'b0, 64'h0);
            if (imem_req && !seen) begin
                seen = 1'b1;
                chk("redir_addr", imem_addr, 64'h2000);
            end
            if (if_valid) begin
                done = 1'b1;
                chk("redir_first_pc", if_pc, 64'h2000);
                chk("redir_first_instr", 64'(if_instr), 64'(mem_word(64'h2000)));
            end
        end
        chk("redir_wait_done", done, 1);

        // Redirect coinciding with an ack while 2 entries are queued and decode is ready.
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        lat  = 2;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            cycle(1'b0, 1'b0, 1'b0, 64'h0);
            if (exp_q.size() == 2 && imem_req && wait_cnt == 1) done = 1'b1;
        end
        chk("rack_found", done, 1);
        cycle(1'b0, 1'b1, 1'b1, 64'h3000);
        chk("rack_ack_seen", imem_ack, 1);
        cycle(1'b0, 1'b1, 1'b0, 64'h0);
        chk("rack_flushed", if_valid, 0);
        chk("rack_req_idle", imem_req, 0);
        cycle(1'b0, 1'b1, 1'b0, 64'h0);
        chk("rack_req", imem_req, 1);
        chk("rack_addr", imem_addr, 64'h3000);

        // PC wrap at the top of the address space (low bits of the target are ignored).
        cycle(1'b1, 1'b1, 1'b0, 64'h0);
        lat = 1;
        cycle(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        seen = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            cycle(1'b0, 1'b1, 1'b0, 64'h0);
            if (imem_req && imem_addr == 64'hFFFF_FFFF_FFFF_FFFC) seen = 1'b1;
            else if (imem_req && seen) begin
                done = 1'b1;
                chk("wrap_addr", imem_addr, 64'h0);
            end
        end
        chk("wrap_done", done, 1);

        // Reset arriving together with an ack mid-request.
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        lat  = 2;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            cycle(1'b0, 1'b0, 1'b0, 64'h0);
            if (exp_q.size() >= 1 && imem_req && wait_cnt == 1) done = 1'b1;
        end
        chk("rst_found", done, 1);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        chk("rst_ack_seen", imem_ack, 1);
        cycle(1'b0, 1'b0, 1'b0, 64'h0);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_addr", imem_addr, RPC);

        // Random traffic against the model.
        rand_ack = 1'b1;
        repeat (800) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_rd  = ($urandom_range(0, 15) == 0);
            r_pc  = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) r_pc = 64'hFFFF_FFFF_FFFF_FFF0 | {60'h0, r_pc[3:0]};
            cycle(r_rst, ($urandom_range(0, 3) != 0), r_rd, r_pc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
